bus_src_arbiter: RTL

Parametrised, registered successor to the datapath bus-source encoder. It samples the N one-hot "Xout" source-drive requests from control, encodes the winner into a bus-mux select, and holds the grant while locked. It detects and counts multi-driver conflicts and supports fixed-priority or round-robin selection. It sits between the control unit and the bus multiplexer, adding one register stage on the select path.

---
 rtl/bus_src_arbiter_if.sv | 27 ++
 rtl/bus_src_arbiter.sv | 95 +++++++++
 2 files changed

// File: rtl/bus_src_arbiter_if.sv
// Handshake bundle between the control unit (master) and the bus-source arbiter (slave).
// Parameters must match those of the arbiter instance that uses this bundle.
interface bus_src_arbiter_if #(
    parameter int N_SRC = 24,
    parameter int SEL_W = 5,
    parameter int CNT_W = 8
);
    logic [N_SRC-1:0] req;
    logic             enable;
    logic             lock;
    logic             clr_err;
    logic [SEL_W-1:0] sel;
    logic             sel_valid;
    logic             conflict;
    logic             conflict_sticky;
    logic [CNT_W-1:0] conflict_cnt;

    modport master (
        output req, enable, lock, clr_err,
        input  sel, sel_valid, conflict, conflict_sticky, conflict_cnt
    );

    modport slave (
        input  req, enable, lock, clr_err,
        output sel, sel_valid, conflict, conflict_sticky, conflict_cnt
    );
endinterface

// File: rtl/bus_src_arbiter.sv
// Registered bus-source arbiter: encodes the drive requests into a mux select with
// optional grant lock and round-robin, and tracks multi-driver conflicts.
//
// state     | meaning
// ST_IDLE   | no grant, bus undriven (sel keeps its last value)
// ST_GRANT  | sel valid, re-arbitrated on every enabled cycle
// ST_LOCKED | sel valid and pinned while lock and req[sel] stay high
module bus_src_arbiter #(
    parameter int N_SRC   = 24,
    parameter int SEL_W   = 5,
    parameter int RR_MODE = 0,
    parameter int CNT_W   = 8
) (
    input  logic             clock,
    input  logic             clear,
    bus_src_arbiter_if.slave bus
);
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_GRANT  = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    logic [1:0]       state;
    logic [SEL_W-1:0] sel;
    logic             sel_valid;
    logic [SEL_W-1:0] rr_ptr;
    logic             conflict;
    logic             conflict_sticky;
    logic [CNT_W-1:0] conflict_cnt;

    logic [SEL_W-1:0] winner;
    logic             found;
    logic             holder_req;
    logic             multi;

    // Scan starts at index 0 for fixed priority, or just past the last winner for round-robin.
    always_comb begin
        int base;
        int idx;
        winner = '0;
        found  = 1'b0;
        base   = (RR_MODE != 0) ? int'(rr_ptr) + 1 : 0;
        for (int k = 0; k < N_SRC; k++) begin
            idx = base + k;
            if (idx >= N_SRC) idx = idx - N_SRC;
            if (!found && bus.req[SEL_W'(idx)]) begin
                found  = 1'b1;
                winner = SEL_W'(idx);
            end
        end
    end

    assign holder_req = bus.req[sel];
    assign multi      = ($countones(bus.req) >= 2);

    always_ff @(posedge clock) begin
        if (clear) begin
            state           <= ST_IDLE;
            sel             <= '0;
            sel_valid       <= 1'b0;
            rr_ptr          <= SEL_W'(N_SRC - 1);
            conflict        <= 1'b0;
            conflict_sticky <= 1'b0;
            conflict_cnt    <= '0;
        end else begin
            conflict <= multi;
            if (bus.clr_err) begin
                conflict_sticky <= 1'b0;
                conflict_cnt    <= '0;
            end else if (multi) begin
                conflict_sticky <= 1'b1;
                if (conflict_cnt != {CNT_W{1'b1}}) conflict_cnt <= conflict_cnt + 1'b1;
            end

            if (bus.enable) begin
                if ((state == ST_GRANT || state == ST_LOCKED) && bus.lock && holder_req) begin
                    state <= ST_LOCKED;
                end else if (found) begin
                    state     <= ST_GRANT;
                    sel       <= winner;
                    sel_valid <= 1'b1;
                    rr_ptr    <= winner;
                end else begin
                    state     <= ST_IDLE;
                    sel_valid <= 1'b0;
                end
            end
        end
    end

    assign bus.sel             = sel;
    assign bus.sel_valid       = sel_valid;
    assign bus.conflict        = conflict;
    assign bus.conflict_sticky = conflict_sticky;
    assign bus.conflict_cnt    = conflict_cnt;
endmodule
